// File: rtl/imm_field_packer.sv
// imm_field_packer
//   Encodes a 64-bit constant into the 26-bit LEGv8 instruction immediate
//   field(s) that the immediate sign-extender decodes back to that constant.
//   I/D/B/CB formats produce one beat with a range error flag. IM (MOVZ/MOVK)
//   produces one beat per nonzero 16-bit halfword, in ascending halfword
//   order. Illegal format codes produce one zero beat flagged as an error.
//
// Ports
//   CLK        in   1   clock, rising edge
//   resetl     in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   high in IDLE; a request is taken on valid && ready
//   req_ctrl   in   3   0=I 1=D 2=B 3=CB 4=IM 5..7 illegal
//   req_value  in   64  constant to encode
//   out_valid  out  1   beat valid
//   out_ready  in   1   consumer accepts beat
//   out_field  out  26  instruction bits [25:0], non-immediate bits zero
//   out_ctrl   out  3   format code of the request being emitted
//   out_movk   out  1   IM only: 0 = MOVZ beat, 1 = MOVK beat
//   out_last   out  1   final beat of the request
//   out_err    out  1   value not representable, or illegal format
module imm_field_packer (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_ctrl,
    input  logic [63:0] req_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] out_field,
    output logic [2:0]  out_ctrl,
    output logic        out_movk,
    output logic        out_last,
    output logic        out_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [63:0] value_q;
    logic [3:0]  mask_q;     // halfwords still to be emitted after the current beat

    // True when the value fits an n-bit two's complement field: every bit
    // from position n-1 upward must equal the sign.
    function automatic logic fits_signed(input logic [63:0] v, input int unsigned n);
        logic signed [63:0] s;
        s = $signed(v) >>> (n - 1);
        return (s == '0) || (s == '1);
    endfunction

    logic        accept;
    logic        advance;
    logic [63:0] src_value;
    logic [3:0]  src_mask;
    logic [3:0]  req_nz;
    logic [1:0]  hw_sel;
    logic        hw_found;
    logic [15:0] imm16;
    logic [3:0]  mask_rest;
    logic [25:0] im_field;

    logic [25:0] first_field;
    logic        first_last;
    logic        first_err;

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign accept    = (state_q == IDLE) && req_valid;
    // Further IM beats only ever follow a non-last beat being taken.
    assign advance   = (state_q == EMIT) && out_ready && !out_last;

    assign req_nz = {|req_value[63:48], |req_value[47:32],
                     |req_value[31:16], |req_value[15:0]};

    // The same halfword picker serves the first beat (from the request) and
    // later beats (from the registered value and remaining mask).
    assign src_value = (state_q == IDLE) ? req_value : value_q;
    assign src_mask  = (state_q == IDLE) ? req_nz    : mask_q;

    always_comb begin
        hw_sel   = 2'd0;
        hw_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (src_mask[i] && !hw_found) begin
                hw_sel   = i[1:0];
                hw_found = 1'b1;
            end
        end
    end

    assign imm16     = src_value[{hw_sel, 4'b0000} +: 16];
    assign mask_rest = src_mask & ~(4'b0001 << hw_sel);
    assign im_field  = {3'b000, hw_sel, imm16, 5'b00000};

    always_comb begin
        first_field = '0;
        first_last  = 1'b1;
        first_err   = 1'b0;
        case (req_ctrl)
            3'd0: begin
                first_field = {4'b0000, req_value[11:0], 10'b0};
                first_err   = !fits_signed(req_value, 12);
            end
            3'd1: begin
                first_field = {5'b00000, req_value[8:0], 12'b0};
                first_err   = !fits_signed(req_value, 9);
            end
            3'd2: begin
                first_field = req_value[25:0];
                first_err   = !fits_signed(req_value, 26);
            end
            3'd3: begin
                first_field = {2'b00, req_value[18:0], 5'b00000};
                first_err   = !fits_signed(req_value, 19);
            end
            3'd4: begin
                // A zero constant still yields one MOVZ beat (hw=0, imm=0).
                first_field = im_field;
                first_last  = (mask_rest == 4'b0000);
            end
            default: begin
                first_field = '0;
                first_err   = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)             state_d = EMIT;
            EMIT:    if (out_ready && out_last) state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            value_q   <= '0;
            mask_q    <= '0;
            out_field <= '0;
            out_ctrl  <= '0;
            out_movk  <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            value_q   <= req_value;
            mask_q    <= (req_ctrl == 3'd4) ? mask_rest : 4'b0000;
            out_field <= first_field;
            out_ctrl  <= req_ctrl;
            out_movk  <= 1'b0;
            out_last  <= first_last;
            out_err   <= first_err;
        end else if (advance) begin
            mask_q    <= mask_rest;
            out_field <= im_field;
            out_movk  <= 1'b1;
            out_last  <= (mask_rest == 4'b0000);
        end
    end

endmodule

// File: tb/tb_imm_field_packer.sv
module tb_imm_field_packer;

    logic        CLK;
    logic        resetl;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_ctrl;
    logic [63:0] req_value;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_field;
    logic [2:0]  out_ctrl;
    logic        out_movk;
    logic        out_last;
    logic        out_err;

    imm_field_packer dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_value (req_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_ctrl  (out_ctrl),
        .out_movk  (out_movk),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [25:0] field;
        logic        movk;
        logic        last;
        logic        err;
    } beat_t;

    beat_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: encode from the format rules with plain arithmetic.
    task automatic build_model(input logic [2:0] c, input logic [63:0] v);
        int unsigned width;
        int unsigned shift;
        longint      sv;
        longint      lim;
        logic [63:0] low;
        logic [63:0] pos;
        logic [15:0] h;
        int          nz_count;
        int          idx;
        beat_t       b;
        exp_q.delete();
        width = 0;
        shift = 0;
        case (c)
            3'd0: begin width = 12; shift = 10; end
            3'd1: begin width = 9;  shift = 12; end
            3'd2: begin width = 26; shift = 0;  end
            3'd3: begin width = 19; shift = 5;  end
            default: ;
        endcase
        if (c <= 3'd3) begin
            sv  = longint'(v);
            lim = longint'(64'd1 << (width - 1));
            low = v & ((64'd1 << width) - 64'd1);
            pos = low << shift;
            b.field = pos[25:0];
            b.movk  = 1'b0;
            b.last  = 1'b1;
            b.err   = (sv < -lim) || (sv > lim - 1);
            exp_q.push_back(b);
        end else if (c == 3'd4) begin
            nz_count = 0;
            for (int hw = 0; hw < 4; hw++)
                if (v[hw*16 +: 16] != 16'h0) nz_count++;
            if (nz_count == 0) begin
                b.field = '0; b.movk = 1'b0; b.last = 1'b1; b.err = 1'b0;
                exp_q.push_back(b);
            end else begin
                idx = 0;
                for (int hw = 0; hw < 4; hw++) begin
                    h = v[hw*16 +: 16];
                    if (h != 16'h0) begin
                        pos = (64'(hw) * 64'h20_0000) + (64'(h) * 64'd32);
                        b.field = pos[25:0];
                        b.movk  = (idx != 0);
                        b.last  = (idx == nz_count - 1);
                        b.err   = 1'b0;
                        exp_q.push_back(b);
                        idx++;
                    end
                end
            end
        end else begin
            b.field = '0; b.movk = 1'b0; b.last = 1'b1; b.err = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic check_beat(input string tag, input beat_t b, input logic [2:0] c);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".field"}, out_field, b.field);
        check({tag, ".movk"},  out_movk,  b.movk);
        check({tag, ".last"},  out_last,  b.last);
        check({tag, ".err"},   out_err,   b.err);
        check({tag, ".ctrl"},  out_ctrl,  c);
        check({tag, ".rdy"},   req_ready, 1'b0);
    endtask

    // Issue one request and consume all its beats; stall_max bounds the
    // random number of cycles out_ready is held low before each beat,
    // force_stall (if nonzero) stalls exactly that long before beat 1.
    task automatic run_req(input string tag, input logic [2:0] c, input logic [63:0] v,
                           input int stall_max, input int force_stall);
        int stall;
        beat_t b;
        build_model(c, v);
        @(negedge CLK);
        check({tag, ".req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_ctrl  = c;
        req_value = v;
        out_ready = 1'b0;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        req_value = $urandom();
        foreach (exp_q[i]) begin
            b = exp_q[i];
            @(negedge CLK);
            check_beat($sformatf("%s.b%0d", tag, i), b, c);
            stall = (force_stall != 0 && i == 1) ? force_stall
                  : $urandom_range(0, stall_max);
            repeat (stall) begin
                @(negedge CLK);
                check_beat($sformatf("%s.b%0d.hold", tag, i), b, c);
            end
            out_ready = 1'b1;
            @(posedge CLK);
            #1 out_ready = 1'b0;
        end
        @(negedge CLK);
        check({tag, ".idle_valid"}, out_valid, 1'b0);
        check({tag, ".idle_ready"}, req_ready, 1'b1);
    endtask

    function automatic logic [63:0] rand_value(input logic [2:0] c);
        logic [63:0] r;
        int unsigned w;
        int unsigned mode;
        r = {$urandom(), $urandom()};
        case (c)
            3'd0: w = 12;
            3'd1: w = 9;
            3'd2: w = 26;
            3'd3: w = 19;
            default: w = 16;
        endcase
        mode = $urandom_range(0, 3);
        case (mode)
            0: return r;
            1: return {{64{r[w-1]}}} & ~((64'd1 << w) - 64'd1) | (r & ((64'd1 << w) - 64'd1));
            2: case ($urandom_range(0, 3))
                   0: return 64'd1 << (w - 1);
                   1: return (64'd1 << (w - 1)) - 64'd1;
                   2: return -(64'd1 << (w - 1));
                   default: return -(64'd1 << (w - 1)) - 64'd1;
               endcase
            default: begin
                for (int hw = 0; hw < 4; hw++)
                    if ($urandom_range(0, 1) == 0) r[hw*16 +: 16] = 16'h0;
                return r;
            end
        endcase
    endfunction

    initial begin
        logic [2:0] rc;
        resetl    = 1'b0;
        req_valid = 1'b0;
        req_ctrl  = '0;
        req_value = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst.valid", out_valid, 1'b0);
        check("rst.ready", req_ready, 1'b1);
        check("rst.field", out_field, 26'h0);
        check("rst.ctrl",  out_ctrl,  3'd0);
        check("rst.movk",  out_movk,  1'b0);
        check("rst.last",  out_last,  1'b0);
        check("rst.err",   out_err,   1'b0);
        resetl = 1'b1;

        // Directed cases, model expectations cross-checked with literals.
        build_model(3'd0, 64'd1);
        check("lit.i1", exp_q[0].field, 26'h0000400);
        build_model(3'd4, 64'hce31_0000_0000_0a0c);
        check("lit.im_b2", exp_q[1].field, 26'h079c620);

        run_req("i_1",    3'd0, 64'd1, 0, 0);
        run_req("i_m36",  3'd0, -64'd36, 0, 0);
        run_req("d_1",    3'd1, 64'd1, 0, 0);
        run_req("d_m36",  3'd1, -64'd36, 0, 0);
        run_req("cb_1",   3'd3, 64'd1, 0, 0);
        run_req("i_2048", 3'd0, 64'd2048, 0, 0);
        run_req("b_max",  3'd2, 64'h1ff_ffff, 0, 0);
        run_req("b_ovf",  3'd2, 64'h200_0000, 0, 0);
        run_req("im_ex",  3'd4, 64'hce31_0000_0000_0a0c, 0, 0);
        run_req("im_0",   3'd4, 64'd0, 0, 0);
        run_req("im_bp",  3'd4, 64'h1111_2222_3333_4444, 0, 5);
        run_req("ill6",   3'd6, 64'hdead_beef_0123_4567, 0, 0);

        // Reset between beats of a 4-beat IM request.
        @(negedge CLK);
        req_valid = 1'b1;
        req_ctrl  = 3'd4;
        req_value = 64'h0004_0003_0002_0001;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        check("rstm.b0.valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        check("rstm.b1.valid", out_valid, 1'b1);
        check("rstm.b1.movk",  out_movk,  1'b1);
        #2 resetl = 1'b0;
        #1;
        check("rstm.async_valid", out_valid, 1'b0);
        check("rstm.async_field", out_field, 26'h0);
        check("rstm.async_ready", req_ready, 1'b1);
        @(negedge CLK);
        resetl    = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("rstm.no_stale", out_valid, 1'b0);
            check("rstm.ready",    req_ready, 1'b1);
        end
        out_ready = 1'b0;
        run_req("post_rst", 3'd4, 64'h0004_0003_0002_0001, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            rc = 3'($urandom_range(0, 7));
            run_req($sformatf("rnd%0d", n), rc, rand_value(rc), 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
